// File: rtl/vision_stream_pkg.sv
// Shared types for the vision pixel-stream blocks: beat layout, mux FSM states and
// the default frame geometry.
package vision_stream_pkg;

  localparam int BEAT_DATA_W   = 30;
  localparam int FRAME_WIDTH   = 640;
  localparam int FRAME_HEIGHT  = 480;
  localparam int PIX_PER_FRAME = FRAME_WIDTH * FRAME_HEIGHT;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   sop;
    logic                   eop;
  } st_beat_t;

  typedef enum logic {
    SEEK,
    STREAM
  } mux_state_t;

  function automatic int pix_per_frame(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry Avalon-ST register slice. in_ready comes straight from a flop, so there is
// no combinational path from out_ready back to in_ready.
module stream_skid_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic [1:0]   count_reg;
  logic         full_reg;
  logic         push;
  logic         pop;

  assign in_ready  = ~full_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = head_reg;
  assign push      = in_valid & ~full_reg;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
      full_reg  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= in_data;
          else                   tail_reg <= in_data;
          count_reg <= count_reg + 2'd1;
          full_reg  <= (count_reg == 2'd1);
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
          full_reg  <= 1'b0;
        end
        // push and pop together only happens with exactly one entry held
        2'b11: head_reg <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_aligned_stream_mux.sv
// N-input pixel stream selector that switches channel only between frames, checks
// each frame's length and drives a registered output through a skid buffer.
module frame_aligned_stream_mux
  import vision_stream_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DATA_W          = 30,
  parameter int WIDTH           = 640,
  parameter int HEIGHT          = 480,
  parameter bit DROP_UNSELECTED = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(NUM_CH)-1:0] sel_i,
  input  logic [NUM_CH*DATA_W-1:0]  data_i,
  input  logic [NUM_CH-1:0]         startofpacket_i,
  input  logic [NUM_CH-1:0]         endofpacket_i,
  input  logic [NUM_CH-1:0]         valid_i,
  output logic [NUM_CH-1:0]         ready_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      startofpacket_o,
  output logic                      endofpacket_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(NUM_CH)-1:0] active_ch_o,
  output logic [15:0]               frame_count_o,
  output logic                      frame_err_o
);

  localparam int SEL_W     = $clog2(NUM_CH);
  localparam int FRAME_PIX = pix_per_frame(WIDTH, HEIGHT);
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_PIX - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  mux_state_t        state_reg, state_next;
  logic [SEL_W-1:0]  pend_sel_reg, active_ch_reg, active_ch_next, sel_clamped;
  logic [CNT_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [15:0]       frame_count_reg;
  logic              frame_err_reg;
  logic              count_inc, err_set;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic              act_valid, act_sop, act_eop, act_ready;
  logic              accept, forward, truncated, overlong;
  beat_t             skid_in, skid_out;

  assign sel_clamped = ({1'b0, sel_i} > (SEL_W+1)'(NUM_CH - 1)) ? SEL_W'(NUM_CH - 1) : sel_i;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi] = data_i[gi*DATA_W +: DATA_W];
      assign ready_o[gi] = (active_ch_reg == SEL_W'(gi)) ? act_ready : DROP_UNSELECTED;
    end
  endgenerate

  assign act_valid = valid_i[active_ch_reg];
  assign act_sop   = startofpacket_i[active_ch_reg];
  assign act_eop   = endofpacket_i[active_ch_reg];
  // The SOP that ends SEEK needs buffer space too, so both states honour skid_full.
  assign accept    = act_valid & act_ready;
  assign forward   = accept & ((state_reg == STREAM) | act_sop);
  assign truncated = act_sop & (state_reg == STREAM);
  assign overlong  = ~act_sop & (pix_cnt_reg == LAST_CNT);

  always_comb begin
    state_next     = state_reg;
    pix_cnt_next   = pix_cnt_reg;
    active_ch_next = active_ch_reg;
    count_inc      = 1'b0;
    err_set        = 1'b0;
    if (forward) begin
      if (act_sop) begin
        pix_cnt_next = CNT_W'(1);
        err_set      = truncated;
        state_next   = STREAM;
      end else if (!overlong) begin
        pix_cnt_next = pix_cnt_reg + CNT_W'(1);
        err_set      = ~act_eop & (pix_cnt_reg == PRE_LAST);
      end
      if (act_eop) begin
        state_next = SEEK;
        if ((pix_cnt_next == LAST_CNT) && !truncated && !overlong) count_inc = 1'b1;
        else                                                      err_set   = 1'b1;
      end
    end
    if (((state_reg == SEEK) && !forward) || (accept && act_eop))
      active_ch_next = pend_sel_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= SEEK;
      pend_sel_reg    <= '0;
      active_ch_reg   <= '0;
      pix_cnt_reg     <= '0;
      frame_count_reg <= '0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_sel_reg  <= sel_clamped;
      active_ch_reg <= active_ch_next;
      pix_cnt_reg   <= pix_cnt_next;
      frame_err_reg <= err_set;
      if (count_inc) frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign skid_in = '{data: ch_data[active_ch_reg], sop: act_sop, eop: act_eop};

  stream_skid_buffer #(
    .W(DATA_W + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (forward),
    .in_ready (act_ready),
    .in_data  (skid_in),
    .out_valid(valid_o),
    .out_ready(ready_i),
    .out_data (skid_out)
  );

  assign data_o          = skid_out.data;
  assign startofpacket_o = skid_out.sop;
  assign endofpacket_o   = skid_out.eop;
  assign active_ch_o     = active_ch_reg;
  assign frame_count_o   = frame_count_reg;
  assign frame_err_o     = frame_err_reg;

endmodule
